garegga_pcm_cache: RTL

- Read cache between the OKI/NMK112 PCM byte port of the Garegga sound block (PCM_CS/PCM_ADDR/PCM_DOUT/PCM_OK) and the 16-bit SDRAM PCM ROM channel.
- Direct-mapped line cache: serves repeat ADPCM nibble-pair fetches in a few cycles and turns misses into short sequential word fills.
- Cuts SDRAM PCM bandwidth so the Z80 ROM and graphics channels see less contention.

---
 rtl/garegga_snd_pkg.sv | 21 ++
 rtl/garegga_pcm_cache_ram.sv | 22 ++
 rtl/garegga_pcm_cache.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/garegga_snd_pkg.sv
// Shared types and width helpers for the Garegga sound-side PCM cache.
package garegga_snd_pkg;

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} fill_st_e;

  // PCM_ADDR bit that picks the byte lane inside a 16-bit ROM word
  localparam int LANE_BIT = 0;

  function automatic int ofs_w(input int words);
    return $clog2(words * 2);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int aw, input int lines, input int words);
    return aw - ofs_w(words) - idx_w(lines);
  endfunction

endpackage

// File: rtl/garegga_pcm_cache_ram.sv
// Line data store: one fill write port, one registered read port for the hit path.
module garegga_pcm_cache_ram #(
  parameter int DEPTH = 64,
  parameter int AWID  = 6
) (
  input  logic            CLK96,
  input  logic            we,
  input  logic [AWID-1:0] waddr,
  input  logic [15:0]     wdata,
  input  logic [AWID-1:0] raddr,
  output logic [15:0]     rdata
);

  logic [15:0] mem [DEPTH];

  // Write-first is irrelevant: reads are only consumed in IDLE, writes only happen in REQ
  always_ff @(posedge CLK96) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/garegga_pcm_cache.sv
// Direct-mapped read cache between the OKI/NMK112 PCM byte port and the 16-bit SDRAM PCM channel.
// Optional debug counters HIT_CNT/MISS_CNT when GAREGGA_PCM_CACHE_STATS_EN is defined.
module garegga_pcm_cache
  import garegga_snd_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int AW    = 20
) (
  input  logic          CLK96,
  input  logic          RESET96_N,
  input  logic          PCM_CS,
  input  logic [AW-1:0] PCM_ADDR,
  output logic [7:0]    PCM_DOUT,
  output logic          PCM_OK,
  input  logic          INVALIDATE,
  output logic          SDR_CS,
  output logic [AW-2:0] SDR_ADDR,
  input  logic [15:0]   SDR_DATA,
  input  logic          SDR_OK
`ifdef GAREGGA_PCM_CACHE_STATS_EN
  ,
  output logic [15:0]   HIT_CNT,
  output logic [15:0]   MISS_CNT
`endif
);

  localparam int OFS = ofs_w(WORDS);
  localparam int IDX = idx_w(LINES);
  localparam int TAG = tag_w(AW, LINES, WORDS);
  localparam int WB  = OFS - 1;

  logic [IDX-1:0] a_idx;
  logic [TAG-1:0] a_tag;
  logic [WB-1:0]  a_word;
  logic           hit;

  fill_st_e       st;
  logic [WB-1:0]  wc;
  logic [IDX-1:0] f_idx;
  logic [TAG-1:0] f_tag;
  logic           fill_kill;
  logic           ok_q;
  logic [AW-1:0]  addr_q;
  logic           sdr_cs;
  logic [AW-2:0]  sdr_addr;

  logic [TAG-1:0] tag_r [LINES];
  logic [LINES-1:0] valid;
  logic [15:0]    rdata;

  assign a_word = PCM_ADDR[1 +: WB];
  assign a_idx  = PCM_ADDR[OFS +: IDX];
  assign a_tag  = PCM_ADDR[AW-1 -: TAG];
  assign hit    = valid[a_idx] && (tag_r[a_idx] == a_tag);

  garegga_pcm_cache_ram #(.DEPTH(LINES*WORDS), .AWID(IDX+WB)) u_ram (
    .CLK96 (CLK96),
    .we    ((st == REQ) && SDR_OK),
    .waddr ({f_idx, wc}),
    .wdata (SDR_DATA),
    .raddr ({a_idx, a_word}),
    .rdata (rdata)
  );

  // Combinational address compare means OK can never outlive the address it was issued for
  assign PCM_OK   = ok_q && PCM_CS && (PCM_ADDR == addr_q);
  assign PCM_DOUT = !ok_q ? 8'h00 : (addr_q[LANE_BIT] ? rdata[15:8] : rdata[7:0]);
  assign SDR_CS   = sdr_cs;
  assign SDR_ADDR = sdr_addr;

  // Tags only change when a fill completes
  always_ff @(posedge CLK96) begin
    if (st == DONE) tag_r[f_idx] <= f_tag;
  end

  // Hit tracking and line-fill sequencer
  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      st        <= IDLE;
      wc        <= '0;
      f_idx     <= '0;
      f_tag     <= '0;
      fill_kill <= 1'b0;
      ok_q      <= 1'b0;
      addr_q    <= '0;
      sdr_cs    <= 1'b0;
      sdr_addr  <= '0;
      valid     <= '0;
    end else begin
      case (st)
        IDLE: begin
          ok_q   <= PCM_CS && hit;
          addr_q <= PCM_ADDR;
          if (PCM_CS && !hit && !INVALIDATE) begin
            st           <= REQ;
            f_idx        <= a_idx;
            f_tag        <= a_tag;
            wc           <= '0;
            fill_kill    <= 1'b0;
            valid[a_idx] <= 1'b0;
            sdr_cs       <= 1'b1;
            sdr_addr     <= {a_tag, a_idx, {WB{1'b0}}};
          end
        end
        REQ: begin
          if (SDR_OK) begin
            sdr_cs <= 1'b0;
            st     <= GAP;
          end
        end
        GAP: begin
          // One idle cycle so a held SDR_OK is never taken as the next word
          if (wc == WB'(WORDS-1)) begin
            st <= DONE;
          end else begin
            wc       <= wc + 1'b1;
            sdr_cs   <= 1'b1;
            sdr_addr <= {f_tag, f_idx, wc + 1'b1};
            st       <= REQ;
          end
        end
        DONE: begin
          valid[f_idx] <= !fill_kill;
          st           <= IDLE;
        end
        default: st <= IDLE;
      endcase
      // Invalidate overrides anything written above, including a DONE install
      if (INVALIDATE) begin
        valid <= '0;
        ok_q  <= 1'b0;
        if (st != IDLE) fill_kill <= 1'b1;
      end
    end
  end

`ifdef GAREGGA_PCM_CACHE_STATS_EN
  logic new_hit, new_miss;
  assign new_hit  = (st == IDLE) && PCM_CS && hit && !(ok_q && (addr_q == PCM_ADDR));
  assign new_miss = (st == IDLE) && PCM_CS && !hit;

  // Saturating debug counters
  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      HIT_CNT  <= '0;
      MISS_CNT <= '0;
    end else if (INVALIDATE) begin
      HIT_CNT  <= '0;
      MISS_CNT <= '0;
    end else begin
      if (new_hit && (HIT_CNT != 16'hFFFF))   HIT_CNT  <= HIT_CNT + 16'd1;
      if (new_miss && (MISS_CNT != 16'hFFFF)) MISS_CNT <= MISS_CNT + 16'd1;
    end
  end
`endif

endmodule
